// File: rtl/i2s_rx_deserializer_if.sv
// I2S receive bundle: serial bit-clock/word-select/data going in, parallel
// PCM words, strobes and health status coming out.
`timescale 1ns/1ps
interface i2s_rx_deserializer_if #(
  parameter int WIDTH = 24
) ();
  logic             i2s_bck;
  logic             i2s_ws;
  logic             i2s_d0;
  logic [WIDTH-1:0] l_data;
  logic [WIDTH-1:0] r_data;
  logic             frame_valid;
  logic             slot_err;
  logic [5:0]       slot_len;
  logic             locked;

  // Source side: drives the serial stream, observes the decoded words
  modport master (
    output i2s_bck, i2s_ws, i2s_d0,
    input  l_data, r_data, frame_valid, slot_err, slot_len, locked
  );

  // Deserialiser side: consumes the serial stream, produces the decoded words
  modport slave (
    input  i2s_bck, i2s_ws, i2s_d0,
    output l_data, r_data, frame_valid, slot_err, slot_len, locked
  );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// Oversampled I2S receiver. Synchronises bck/ws/d0 into clk_in, detects bck
// rising edges and shifts data MSB-first into left/right PCM words. Reports
// slot length, slot length errors, a per-pair valid strobe and a lock flag
// that drops on errors or when bck stops toggling.
`timescale 1ns/1ps
module i2s_rx_deserializer #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int TIMEOUT   = 255
) (
  input logic                  clk_in,
  input logic                  reset,
  i2s_rx_deserializer_if.slave bus
);

  typedef enum logic {SYNC, RUN} stateT;

  localparam logic [6:0] WIDTH_C    = 7'(WIDTH);
  localparam logic [6:0] SLOT_C     = 7'(SLOT_BITS);
  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  logic             r_bckS1, r_bckS2, r_bckS3;
  logic             r_wsS1, r_wsS2;
  logic             r_dS1, r_dS2;

  stateT            r_state;
  logic             r_wsLast;
  logic [5:0]       r_bitCnt;
  logic [WIDTH-1:0] r_shReg;
  logic             r_haveLeft;
  logic             r_leftErr;
  logic [7:0]       r_idle;

  logic [WIDTH-1:0] r_lData;
  logic [WIDTH-1:0] r_rData;
  logic             r_frameValid;
  logic             r_slotErr;
  logic [5:0]       r_slotLen;
  logic             r_locked;

  logic             w_bckRise;
  logic             w_wsChg;
  logic [6:0]       w_bitInc;
  logic             w_keepBit;
  logic [WIDTH-1:0] w_shNext;
  logic [6:0]       w_nBits;
  logic [WIDTH-1:0] w_word;
  logic [5:0]       w_slotLenSat;
  logic             w_lenErr;
  logic [5:0]       w_bitCntNext;

  // Bring the asynchronous-looking I2S pins into clk_in; bck gets a third
  // stage so its rising edge can be detected on synchronised samples.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_bckS1 <= 1'b0;
      r_bckS2 <= 1'b0;
      r_bckS3 <= 1'b0;
      r_wsS1  <= 1'b0;
      r_wsS2  <= 1'b0;
      r_dS1   <= 1'b0;
      r_dS2   <= 1'b0;
    end else begin
      r_bckS1 <= bus.i2s_bck;
      r_bckS2 <= r_bckS1;
      r_bckS3 <= r_bckS2;
      r_wsS1  <= bus.i2s_ws;
      r_wsS2  <= r_wsS1;
      r_dS1   <= bus.i2s_d0;
      r_dS2   <= r_dS1;
    end
  end

  assign w_bckRise    = r_bckS2 & ~r_bckS3;
  assign w_wsChg      = r_wsS2 ^ r_wsLast;
  assign w_bitInc     = {1'b0, r_bitCnt} + 7'd1;
  assign w_keepBit    = ({1'b0, r_bitCnt} < WIDTH_C);
  assign w_shNext     = w_keepBit ? {r_shReg[WIDTH-2:0], r_dS2} : r_shReg;
  assign w_nBits      = (w_bitInc > WIDTH_C) ? WIDTH_C : w_bitInc;
  assign w_word       = w_shNext << (WIDTH_C - w_nBits);
  assign w_slotLenSat = (w_bitInc > 7'd63) ? 6'd63 : w_bitInc[5:0];
  assign w_lenErr     = (w_bitInc != SLOT_C);
  assign w_bitCntNext = (r_bitCnt == 6'd63) ? 6'd63 : r_bitCnt + 6'd1;

  // Frame FSM: align on a ws edge, shift bits, commit words on each ws edge
  // (the ws-change bit is still the LSB of the old word), track lock/timeout.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= SYNC;
      r_wsLast     <= 1'b0;
      r_bitCnt     <= '0;
      r_shReg      <= '0;
      r_haveLeft   <= 1'b0;
      r_leftErr    <= 1'b0;
      r_idle       <= '0;
      r_lData      <= '0;
      r_rData      <= '0;
      r_frameValid <= 1'b0;
      r_slotErr    <= 1'b0;
      r_slotLen    <= '0;
      r_locked     <= 1'b0;
    end else begin
      r_frameValid <= 1'b0;
      r_slotErr    <= 1'b0;
      if (w_bckRise) begin
        r_idle   <= '0;
        r_wsLast <= r_wsS2;
        case (r_state)
          SYNC: begin
            if (w_wsChg) begin
              r_state    <= RUN;
              r_bitCnt   <= '0;
              r_shReg    <= '0;
              r_haveLeft <= 1'b0;
              r_leftErr  <= 1'b0;
            end
          end
          RUN: begin
            if (!w_wsChg) begin
              r_shReg  <= w_shNext;
              r_bitCnt <= w_bitCntNext;
            end else begin
              r_slotLen <= w_slotLenSat;
              r_slotErr <= w_lenErr;
              r_bitCnt  <= '0;
              r_shReg   <= '0;
              if (!r_wsLast) begin
                r_lData    <= w_word;
                r_haveLeft <= 1'b1;
                r_leftErr  <= w_lenErr;
                if (w_lenErr) r_locked <= 1'b0;
              end else begin
                r_rData <= w_word;
                if (r_haveLeft) begin
                  r_frameValid <= 1'b1;
                  r_haveLeft   <= 1'b0;
                end
                if (w_lenErr) r_locked <= 1'b0;
                else if (r_haveLeft && !r_leftErr) r_locked <= 1'b1;
              end
            end
          end
          default: r_state <= SYNC;
        endcase
      end else if (r_idle != TIMEOUT_C) begin
        r_idle <= r_idle + 8'd1;
        if (r_idle == TIMEOUT_M1) begin
          r_locked   <= 1'b0;
          r_state    <= SYNC;
          r_haveLeft <= 1'b0;
        end
      end
    end
  end

  assign bus.l_data      = r_lData;
  assign bus.r_data      = r_rData;
  assign bus.frame_valid = r_frameValid;
  assign bus.slot_err    = r_slotErr;
  assign bus.slot_len    = r_slotLen;
  assign bus.locked      = r_locked;

endmodule
